// File: rtl/stack_ctrl_pkg.sv
// Shared definitions for the stack-machine sequencing controller:
// opcode groups, FSM states, fault codes and the per-group decode record.
package stack_ctrl_pkg;

    localparam logic [2:0] GRP_ALU2     = 3'b000;
    localparam logic [2:0] GRP_ALU1     = 3'b100;
    localparam logic [2:0] GRP_PUSH_MEM = 3'b010;
    localparam logic [2:0] GRP_POP_MEM  = 3'b110;
    localparam logic [2:0] GRP_CMP      = 3'b001;
    localparam logic [2:0] GRP_BR       = 3'b011;
    localparam logic [2:0] GRP_PUSH_PC  = 3'b101;
    localparam logic [2:0] GRP_POP_PC   = 3'b111;

    localparam logic [1:0] FC_NONE    = 2'b00;
    localparam logic [1:0] FC_UNDER   = 2'b01;
    localparam logic [1:0] FC_OVER    = 2'b10;
    localparam logic [1:0] FC_ILLEGAL = 2'b11;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_POP    = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_PUSH   = 3'd5,
        ST_FAULT  = 3'd6
    } state_t;

    typedef struct packed {
        logic [1:0] np;
        logic [1:0] nu;
        logic       alu_src;
        logic       mem;
        logic       mem_we;
        logic       mem_to_reg;
    } group_info_t;

endpackage

// File: rtl/stack_grp_decode.sv
// Combinational opcode-group lookup: pop/push counts and datapath flags.
module stack_grp_decode
    import stack_ctrl_pkg::*;
(
    input  logic [2:0]  opcode,
    output group_info_t info
);

    always_comb begin
        info = '0;
        case (opcode)
            GRP_ALU2:     begin info.np = 2'd2; info.nu = 2'd1; end
            GRP_ALU1:     begin info.np = 2'd1; info.nu = 2'd1; info.alu_src = 1'b1; end
            GRP_PUSH_MEM: begin info.nu = 2'd1; info.mem = 1'b1; info.mem_to_reg = 1'b1; end
            GRP_POP_MEM:  begin info.np = 2'd2; info.mem = 1'b1; info.mem_we = 1'b1; end
            GRP_CMP:      begin info.np = 2'd2; info.nu = 2'd1; end
            GRP_BR:       begin info.np = 2'd1; end
            GRP_PUSH_PC:  begin info.nu = 2'd1; end
            GRP_POP_PC:   begin info.np = 2'd1; end
            default:      info = '0;
        endcase
    end

endmodule

// File: rtl/stack_seq_controller.sv
// Multi-cycle sequencer for the stack datapath: FETCH/DECODE/POP/EXEC/MEM/PUSH
// with stack-pointer ownership, sticky fault reporting and a memory handshake.
module stack_seq_controller
    import stack_ctrl_pkg::*;
#(
    parameter int DEPTH   = 16,
    parameter int SP_W    = 4,
    parameter int FUNCT_W = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               instr_valid,
    output logic               instr_ready,
    input  logic [2:0]         opcode,
    input  logic [FUNCT_W-1:0] funct,
    input  logic               alu_zero,
    output logic               stk_re,
    output logic               stk_we,
    output logic [SP_W-1:0]    stk_addr,
    output logic [SP_W:0]      sp,
    output logic               alu_src,
    output logic [FUNCT_W-1:0] alu_ctrl,
    output logic               mem_req,
    output logic               mem_we,
    input  logic               mem_ack,
    output logic               mem_to_reg,
    output logic               pc_load,
    output logic               fault,
    output logic [1:0]         fault_code
);

    localparam logic [SP_W+1:0] DEPTH_X = (SP_W+2)'(DEPTH);
    localparam logic [SP_W:0]   SP_ONE  = (SP_W+1)'(1);
    localparam logic [SP_W-1:0] ADDR_ONE = (SP_W)'(1);

    state_t             state_q, state_d;
    logic [SP_W:0]      sp_q, sp_d;
    logic [1:0]         cnt_q, cnt_d;
    logic [2:0]         op_q, op_d;
    logic [FUNCT_W-1:0] funct_q, funct_d;
    logic               fault_q, fault_d;
    logic [1:0]         fault_code_q, fault_code_d;

    logic               instr_ready_q, instr_ready_d;
    logic               stk_re_q, stk_re_d;
    logic               stk_we_q, stk_we_d;
    logic [SP_W-1:0]    stk_addr_q, stk_addr_d;
    logic               alu_src_q, alu_src_d;
    logic [FUNCT_W-1:0] alu_ctrl_q, alu_ctrl_d;
    logic               mem_req_q, mem_req_d;
    logic               mem_we_q, mem_we_d;
    logic               mem_to_reg_q, mem_to_reg_d;

    group_info_t        info;
    logic [SP_W+1:0]    sp_ext, np_ext, nu_ext, sp_after;
    logic               underflow, overflow;

    stack_grp_decode u_grp_decode (
        .opcode (op_q),
        .info   (info)
    );

    assign sp_ext    = {1'b0, sp_q};
    assign np_ext    = {{SP_W{1'b0}}, info.np};
    assign nu_ext    = {{SP_W{1'b0}}, info.nu};
    assign underflow = np_ext > sp_ext;
    assign sp_after  = sp_ext - np_ext + nu_ext;
    assign overflow  = sp_after > DEPTH_X;

    always_comb begin
        state_d      = state_q;
        sp_d         = sp_q;
        cnt_d        = cnt_q;
        op_d         = op_q;
        funct_d      = funct_q;
        fault_d      = fault_q;
        fault_code_d = fault_code_q;

        case (state_q)
            ST_FETCH: begin
                if (instr_valid) begin
                    op_d    = opcode;
                    funct_d = funct;
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                if (underflow) begin
                    state_d      = ST_FAULT;
                    fault_d      = 1'b1;
                    fault_code_d = FC_UNDER;
                end else if (overflow) begin
                    state_d      = ST_FAULT;
                    fault_d      = 1'b1;
                    fault_code_d = FC_OVER;
                end else if (info.np != 2'd0) begin
                    cnt_d   = info.np;
                    state_d = ST_POP;
                end else begin
                    state_d = ST_EXEC;
                end
            end
            ST_POP: begin
                sp_d  = sp_q - SP_ONE;
                cnt_d = cnt_q - 2'd1;
                if (cnt_q == 2'd1) state_d = ST_EXEC;
            end
            ST_EXEC: begin
                if (info.mem)              state_d = ST_MEM;
                else if (info.nu != 2'd0)  state_d = ST_PUSH;
                else                       state_d = ST_FETCH;
            end
            ST_MEM: begin
                if (mem_ack) state_d = (info.nu != 2'd0) ? ST_PUSH : ST_FETCH;
            end
            ST_PUSH: begin
                sp_d    = sp_q + SP_ONE;
                state_d = ST_FETCH;
            end
            ST_FAULT: begin
                state_d = ST_FAULT;
            end
            default: begin
                state_d      = ST_FAULT;
                fault_d      = 1'b1;
                fault_code_d = FC_ILLEGAL;
            end
        endcase

        // Outputs are registered off the next state so they line up with state_q.
        instr_ready_d = (state_d == ST_FETCH);
        stk_re_d      = (state_d == ST_POP);
        stk_we_d      = (state_d == ST_PUSH);
        stk_addr_d    = '0;
        if (state_d == ST_POP)  stk_addr_d = sp_d[SP_W-1:0] - ADDR_ONE;
        if (state_d == ST_PUSH) stk_addr_d = sp_d[SP_W-1:0];
        alu_src_d     = (state_d == ST_EXEC) && info.alu_src;
        alu_ctrl_d    = (state_d == ST_EXEC) ? funct_d : '0;
        mem_req_d     = (state_d == ST_MEM);
        mem_we_d      = (state_d == ST_MEM) && info.mem_we;
        mem_to_reg_d  = ((state_d == ST_MEM) || (state_d == ST_PUSH)) && info.mem_to_reg;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_FETCH;
            sp_q          <= '0;
            cnt_q         <= '0;
            op_q          <= '0;
            funct_q       <= '0;
            fault_q       <= 1'b0;
            fault_code_q  <= FC_NONE;
            instr_ready_q <= 1'b1;
            stk_re_q      <= 1'b0;
            stk_we_q      <= 1'b0;
            stk_addr_q    <= '0;
            alu_src_q     <= 1'b0;
            alu_ctrl_q    <= '0;
            mem_req_q     <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_to_reg_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            sp_q          <= sp_d;
            cnt_q         <= cnt_d;
            op_q          <= op_d;
            funct_q       <= funct_d;
            fault_q       <= fault_d;
            fault_code_q  <= fault_code_d;
            instr_ready_q <= instr_ready_d;
            stk_re_q      <= stk_re_d;
            stk_we_q      <= stk_we_d;
            stk_addr_q    <= stk_addr_d;
            alu_src_q     <= alu_src_d;
            alu_ctrl_q    <= alu_ctrl_d;
            mem_req_q     <= mem_req_d;
            mem_we_q      <= mem_we_d;
            mem_to_reg_q  <= mem_to_reg_d;
        end
    end

    assign instr_ready = instr_ready_q;
    assign stk_re      = stk_re_q;
    assign stk_we      = stk_we_q;
    assign stk_addr    = stk_addr_q;
    assign sp          = sp_q;
    assign alu_src     = alu_src_q;
    assign alu_ctrl    = alu_ctrl_q;
    assign mem_req     = mem_req_q;
    assign mem_we      = mem_we_q;
    assign mem_to_reg  = mem_to_reg_q;
    assign fault       = fault_q;
    assign fault_code  = fault_code_q;

    // alu_zero is only meaningful during EXEC, so the branch decision is taken in that cycle.
    assign pc_load = (state_q == ST_EXEC) &&
                     ((op_q == GRP_POP_PC) || ((op_q == GRP_BR) && (alu_zero ^ funct_q[0])));

endmodule

// File: tb/tb_stack_seq_controller.sv
// Scoreboard bench for stack_seq_controller: stimulus queues expected stack/ALU/PC
// events, a monitor process compares them as the DUT strobes; timing and sp checked inline.
module tb_stack_seq_controller;

    localparam int K_POP  = 1;
    localparam int K_PUSH = 2;
    localparam int K_EXEC = 3;
    localparam int K_PC   = 4;

    localparam logic [2:0] OP_ALU2     = 3'b000;
    localparam logic [2:0] OP_ALU1     = 3'b100;
    localparam logic [2:0] OP_PUSH_MEM = 3'b010;
    localparam logic [2:0] OP_POP_MEM  = 3'b110;
    localparam logic [2:0] OP_BR       = 3'b011;
    localparam logic [2:0] OP_PUSH_PC  = 3'b101;
    localparam logic [2:0] OP_POP_PC   = 3'b111;

    typedef struct {
        int kind;
        int val;
    } ev_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       instr_valid = 1'b0;
    logic       instr_ready;
    logic [2:0] opcode = '0;
    logic [2:0] funct = '0;
    logic       alu_zero = 1'b0;
    logic       stk_re, stk_we;
    logic [3:0] stk_addr;
    logic [4:0] sp;
    logic       alu_src;
    logic [2:0] alu_ctrl;
    logic       mem_req, mem_we, mem_to_reg;
    logic       mem_ack = 1'b0;
    logic       pc_load, fault;
    logic [1:0] fault_code;

    int   tests = 0;
    int   fails = 0;
    int   ack_delay = 1;
    int   mem_hi = 0;
    int   mem_we_hi = 0;
    ev_t  exp_q[$];

    stack_seq_controller dut (
        .clk         (clk),
        .reset       (reset),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .opcode      (opcode),
        .funct       (funct),
        .alu_zero    (alu_zero),
        .stk_re      (stk_re),
        .stk_we      (stk_we),
        .stk_addr    (stk_addr),
        .sp          (sp),
        .alu_src     (alu_src),
        .alu_ctrl    (alu_ctrl),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_ack     (mem_ack),
        .mem_to_reg  (mem_to_reg),
        .pc_load     (pc_load),
        .fault       (fault),
        .fault_code  (fault_code)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic expect_ev(input int kind, input int val);
        ev_t e;
        e.kind = kind;
        e.val  = val;
        exp_q.push_back(e);
    endtask

    task automatic mon_ev(input int kind, input int val);
        ev_t e;
        if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_event: got kind %0d val %0d, expected none", kind, val);
        end else begin
            e = exp_q.pop_front();
            chk("event(kind*256+val)", kind * 256 + val, e.kind * 256 + e.val);
        end
    endtask

    // Monitor: compares every strobe the DUT presents against the queued expectations.
    initial begin
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (stk_re) mon_ev(K_POP, int'(stk_addr));
                if (alu_src || alu_ctrl != 3'd0) mon_ev(K_EXEC, int'({alu_src, alu_ctrl}));
                if (pc_load) mon_ev(K_PC, 0);
                if (stk_we) mon_ev(K_PUSH, int'({mem_to_reg, stk_addr}));
                if (mem_req) begin
                    mem_hi++;
                    if (mem_we) mem_we_hi++;
                end
            end
        end
    end

    // Memory responder: acks in the ack_delay-th cycle of a request.
    initial begin
        int held;
        held = 0;
        forever begin
            @(negedge clk);
            if (mem_req && !reset) begin
                held++;
                mem_ack = (held == ack_delay);
            end else begin
                held = 0;
                mem_ack = 1'b0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic accept(input logic [2:0] op, input logic [2:0] f);
        int w;
        w = 0;
        @(negedge clk);
        while (!instr_ready && w < 100) begin
            @(negedge clk);
            w++;
        end
        chk("instr_ready_wait", int'(instr_ready), 1);
        opcode = op;
        funct = f;
        instr_valid = 1'b1;
        @(posedge clk);
        #1 instr_valid = 1'b0;
    endtask

    task automatic run(input string name, input logic [2:0] op, input logic [2:0] f,
                       input int exp_lat, input int exp_sp);
        int lat;
        accept(op, f);
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!instr_ready && lat < 60);
        chk({name, "_latency"}, lat, exp_lat);
        chk({name, "_sp"}, int'(sp), exp_sp);
    endtask

    task automatic do_reset();
        #1 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    initial begin
        int m0, w0, rdy, w;

        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        chk("rst_sp", int'(sp), 0);
        chk("rst_fault", int'(fault), 0);
        chk("rst_fault_code", int'(fault_code), 0);
        chk("rst_instr_ready", int'(instr_ready), 1);
        chk("rst_strobes", int'({stk_re, stk_we, mem_req, pc_load, alu_src, mem_to_reg}), 0);
        chk("rst_alu_ctrl", int'(alu_ctrl), 0);

        for (int i = 0; i < 3; i++) begin
            expect_ev(K_PUSH, i);
            run("push_pc", OP_PUSH_PC, 3'd0, 3, i + 1);
        end

        expect_ev(K_POP, 2);
        expect_ev(K_POP, 1);
        expect_ev(K_EXEC, 2);
        expect_ev(K_PUSH, 1);
        run("alu2", OP_ALU2, 3'b010, 5, 2);

        expect_ev(K_POP, 1);
        expect_ev(K_PC, 0);
        run("pop_pc", OP_POP_PC, 3'd0, 3, 1);

        alu_zero = 1'b1;
        expect_ev(K_POP, 0);
        expect_ev(K_PC, 0);
        run("br_z_taken", OP_BR, 3'd0, 3, 0);

        alu_zero = 1'b0;
        expect_ev(K_PUSH, 0);
        run("push_pc_b", OP_PUSH_PC, 3'd0, 3, 1);
        expect_ev(K_POP, 0);
        run("br_z_not_taken", OP_BR, 3'd0, 3, 0);

        expect_ev(K_PUSH, 0);
        run("push_pc_c", OP_PUSH_PC, 3'd0, 3, 1);
        expect_ev(K_POP, 0);
        expect_ev(K_EXEC, 1);
        expect_ev(K_PC, 0);
        run("br_nz_taken", OP_BR, 3'd1, 3, 0);

        expect_ev(K_PUSH, 0);
        run("push_pc_d", OP_PUSH_PC, 3'd0, 3, 1);
        expect_ev(K_PUSH, 1);
        run("push_pc_e", OP_PUSH_PC, 3'd0, 3, 2);
        ack_delay = 4;
        m0 = mem_hi;
        w0 = mem_we_hi;
        expect_ev(K_POP, 1);
        expect_ev(K_POP, 0);
        run("pop_mem", OP_POP_MEM, 3'd0, 8, 0);
        chk("pop_mem_req_cycles", mem_hi - m0, 4);
        chk("pop_mem_we_cycles", mem_we_hi - w0, 4);

        ack_delay = 2;
        m0 = mem_hi;
        w0 = mem_we_hi;
        expect_ev(K_PUSH, 16);
        run("push_mem", OP_PUSH_MEM, 3'd0, 5, 1);
        chk("push_mem_req_cycles", mem_hi - m0, 2);
        chk("push_mem_we_cycles", mem_we_hi - w0, 0);

        do_reset();
        chk("rst2_sp", int'(sp), 0);
        accept(OP_ALU1, 3'd0);
        @(posedge clk);
        #1;
        chk("under_fault", int'(fault), 1);
        chk("under_code", int'(fault_code), 1);
        rdy = 0;
        repeat (20) begin
            @(negedge clk);
            if (instr_ready) rdy++;
        end
        chk("under_ready_cycles", rdy, 0);
        chk("under_sp", int'(sp), 0);
        chk("under_fault_sticky", int'(fault), 1);

        do_reset();
        chk("rst3_fault", int'(fault), 0);
        for (int i = 0; i < 16; i++) begin
            expect_ev(K_PUSH, i);
            run("fill", OP_PUSH_PC, 3'd0, 3, i + 1);
        end
        accept(OP_PUSH_MEM, 3'd0);
        @(posedge clk);
        #1;
        chk("over_fault", int'(fault), 1);
        chk("over_code", int'(fault_code), 2);
        repeat (3) @(posedge clk);
        #1;
        chk("over_sp", int'(sp), 16);
        chk("over_mem_req", int'(mem_req), 0);
        chk("over_ready", int'(instr_ready), 0);

        do_reset();
        ack_delay = 1000;
        accept(OP_PUSH_MEM, 3'd0);
        w = 0;
        while (!mem_req && w < 20) begin
            @(negedge clk);
            w++;
        end
        chk("abandon_mem_req_seen", int'(mem_req), 1);
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1;
        chk("abandon_ready", int'(instr_ready), 1);
        chk("abandon_sp", int'(sp), 0);
        chk("abandon_mem_req", int'(mem_req), 0);
        chk("abandon_fault", int'(fault), 0);
        reset = 1'b0;

        expect_ev(K_PUSH, 0);
        run("post_reset_push", OP_PUSH_PC, 3'd0, 3, 1);

        repeat (2) @(negedge clk);
        chk("events_left", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
